// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: FSM states, mux select
// codes, instruction fields, ALUOp values and the decoded instruction class.
package multicycle_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALU_WB   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd15;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDU = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SUBU = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_LUI  = 5'd9;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_BNE,
    CLS_JUMP,
    CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps OpCode/Funct to a class, the
// ALUOp used in the execute step, the immediate extension mode and legality.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0]   OpCode,
  input  logic [5:0]   Funct,
  output instr_class_t cls,
  output logic [4:0]   alu_op,
  output logic         ext_op,
  output logic         legal
);

  always_comb begin
    cls    = CLS_ILLEGAL;
    alu_op = ALU_ADD;
    ext_op = 1'b1;
    legal  = 1'b1;
    case (OpCode)
      OP_RTYPE: begin
        cls = CLS_RTYPE;
        case (Funct)
          F_ADD:   alu_op = ALU_ADD;
          F_ADDU:  alu_op = ALU_ADDU;
          F_SUB:   alu_op = ALU_SUB;
          F_SUBU:  alu_op = ALU_SUBU;
          F_SLL:   alu_op = ALU_SLL;
          F_SRL:   alu_op = ALU_SRL;
          F_SLT:   alu_op = ALU_SLT;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          default: begin
            cls   = CLS_ILLEGAL;
            legal = 1'b0;
          end
        endcase
      end
      OP_ADDIU: begin cls = CLS_ITYPE; alu_op = ALU_ADDU; end
      OP_SLTI:  begin cls = CLS_ITYPE; alu_op = ALU_SLT;  end
      // ORI is the only logical immediate; it zero-extends.
      OP_ORI:   begin cls = CLS_ITYPE; alu_op = ALU_OR; ext_op = 1'b0; end
      OP_LUI:   begin cls = CLS_ITYPE; alu_op = ALU_LUI;  end
      OP_LW:    cls = CLS_LOAD;
      OP_SW:    cls = CLS_STORE;
      OP_BEQ:   cls = CLS_BEQ;
      OP_BNE:   cls = CLS_BNE;
      OP_J:     cls = CLS_JUMP;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: Moore FSM driving the shared ALU, PC, IR and the
// unified memory, with a retired-instruction counter and sticky illegal flag.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W             = 32,
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem2reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_op,
  output logic [1:0]       pc_src,
  output logic [4:0]       ALUOp,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  // Only FETCH is a supported reset state; any other setting parks in TRAP.
  localparam logic [3:0] RST_STATE = (RESET_STATE_FETCH == 1) ? S_FETCH : S_TRAP;

  // Memory handshake: mem_read/mem_write are held for as long as the FSM sits
  // in FETCH/MEM_RD/MEM_WR; the access completes in the cycle mem_ready=1.
  logic [3:0]   state_q, state_d;
  instr_class_t cls;
  logic [4:0]   dec_alu_op;
  logic         dec_ext_op;
  logic         legal;
  logic         retire;

  ctrl_decode u_decode (
    .OpCode (OpCode),
    .Funct  (Funct),
    .cls    (cls),
    .alu_op (dec_alu_op),
    .ext_op (dec_ext_op),
    .legal  (legal)
  );

  assign state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!legal) state_d = S_TRAP;
        else begin
          case (cls)
            CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
            CLS_RTYPE:           state_d = S_EXEC_R;
            CLS_ITYPE:           state_d = S_EXEC_I;
            CLS_BEQ, CLS_BNE:    state_d = S_BRANCH;
            CLS_JUMP:            state_d = S_JUMP;
            default:             state_d = S_TRAP;
          endcase
        end
      end
      S_MEM_ADDR: state_d = (cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:   state_d = S_ALU_WB;
      S_MEM_WB,
      S_ALU_WB,
      S_BRANCH,
      S_JUMP:     state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  always_comb begin
    case (state_q)
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_WR:                             retire = mem_ready;
      default:                              retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal <= 1'b1;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    mem2reg   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RT;
    ext_op    = 1'b0;
    pc_src    = PCSRC_ALU;
    ALUOp     = ALU_ADD;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ALUOp     = ALU_ADDU;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          ext_op    = 1'b1;
          ALUOp     = ALU_ADDU;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          ext_op    = 1'b1;
          ALUOp     = ALU_ADD;
        end
        S_MEM_RD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM_WB: begin
          reg_write = 1'b1;
          mem2reg   = 1'b1;
        end
        S_MEM_WR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          ALUOp     = dec_alu_op;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          ext_op    = dec_ext_op;
          ALUOp     = dec_alu_op;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = (OpCode == OP_RTYPE);
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          ALUOp     = ALU_SUB;
          pc_src    = PCSRC_ALUOUT;
          pc_write  = ((cls == CLS_BEQ) && Zero) || ((cls == CLS_BNE) && !Zero);
        end
        S_JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected control vectors are queued when
// an instruction's cycle plan is driven and compared at each falling edge.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int W = 23;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  OpCode, Funct;
  logic        Zero, mem_ready;
  logic        pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic        reg_dst, mem2reg, alu_src_a, ext_op, illegal;
  logic [1:0]  alu_src_b, pc_src;
  logic [4:0]  ALUOp;
  logic [3:0]  state;
  logic [31:0] instr_count;

  multicycle_ctrl #(.CNT_W(32), .RESET_STATE_FETCH(1)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem2reg(mem2reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .pc_src(pc_src), .ALUOp(ALUOp), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [31:0]  exp_count = '0;

  logic [3:0] st_l[$];
  logic       rdy_l[$];
  logic       rst_l[$];
  logic [5:0] cur_op, cur_funct;
  logic       cur_zero;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(
    input logic [3:0] st, input logic pcw, input logic irw, input logic mrd,
    input logic mwr, input logic rw, input logic iod, input logic rdst,
    input logic m2r, input logic srca, input logic ext, input logic [1:0] pcs,
    input logic [1:0] srcb, input logic [4:0] alu);
    return {st, pcw, irw, mrd, mwr, rw, iod, rdst, m2r, srca, ext, pcs, srcb, alu};
  endfunction

  function automatic logic [4:0] r_alu(input logic [5:0] f);
    case (f)
      F_ADD:   return ALU_ADD;
      F_ADDU:  return ALU_ADDU;
      F_SUB:   return ALU_SUB;
      F_SUBU:  return ALU_SUBU;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_SLT:   return ALU_SLT;
      F_SLL:   return ALU_SLL;
      F_SRL:   return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [4:0] i_alu(input logic [5:0] op);
    case (op)
      OP_ADDIU: return ALU_ADDU;
      OP_SLTI:  return ALU_SLT;
      OP_ORI:   return ALU_OR;
      OP_LUI:   return ALU_LUI;
      default:  return ALU_ADD;
    endcase
  endfunction

  // expected control word for one cycle
  function automatic logic [W-1:0] model_vec(input logic [3:0] st, input logic rdy, input logic rs);
    logic take;
    take = ((cur_op == OP_BEQ) && cur_zero) || ((cur_op == OP_BNE) && !cur_zero);
    if (rs) return pack(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0);
    case (st)
      S_FETCH:    return pack(st, rdy, rdy, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, ALU_ADDU);
      S_DECODE:   return pack(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd3, ALU_ADDU);
      S_MEM_ADDR: return pack(st, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'd0, 2'd2, ALU_ADD);
      S_MEM_RD:   return pack(st, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0);
      S_MEM_WB:   return pack(st, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0, 5'd0);
      S_MEM_WR:   return pack(st, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0);
      S_EXEC_R:   return pack(st, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, r_alu(cur_funct));
      S_EXEC_I:   return pack(st, 0, 0, 0, 0, 0, 0, 0, 0, 1, cur_op != OP_ORI, 2'd0, 2'd2,
                              i_alu(cur_op));
      S_ALU_WB:   return pack(st, 0, 0, 0, 0, 1, 0, cur_op == OP_RTYPE, 0, 0, 0, 2'd0, 2'd0, 5'd0);
      S_BRANCH:   return pack(st, take, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd1, 2'd0, ALU_SUB);
      S_JUMP:     return pack(st, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 5'd0);
      default:    return pack(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0);
    endcase
  endfunction

  // driver tasks
  task automatic add_step(input logic [3:0] st, input logic rdy, input logic rs);
    st_l.push_back(st);
    rdy_l.push_back(rdy);
    rst_l.push_back(rs);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] f, input logic z);
    cur_op = op; cur_funct = f; cur_zero = z;
    OpCode = op; Funct = f; Zero = z;
  endtask

  // cycle plan of a legal instruction; fw/mw = mem_ready-low cycles in FETCH/MEM
  task automatic plan_instr(input int fw, input int mw);
    for (int i = 0; i < fw; i++) add_step(S_FETCH, 1'b0, 1'b0);
    add_step(S_FETCH, 1'b1, 1'b0);
    add_step(S_DECODE, 1'b1, 1'b0);
    case (cur_op)
      OP_RTYPE: begin add_step(S_EXEC_R, 1'b1, 1'b0); add_step(S_ALU_WB, 1'b1, 1'b0); end
      OP_LW, OP_SW: begin
        add_step(S_MEM_ADDR, 1'b1, 1'b0);
        for (int i = 0; i < mw; i++)
          add_step((cur_op == OP_LW) ? S_MEM_RD : S_MEM_WR, 1'b0, 1'b0);
        add_step((cur_op == OP_LW) ? S_MEM_RD : S_MEM_WR, 1'b1, 1'b0);
        if (cur_op == OP_LW) add_step(S_MEM_WB, 1'b1, 1'b0);
      end
      OP_BEQ, OP_BNE: add_step(S_BRANCH, 1'b1, 1'b0);
      OP_J:           add_step(S_JUMP, 1'b1, 1'b0);
      default: begin add_step(S_EXEC_I, 1'b1, 1'b0); add_step(S_ALU_WB, 1'b1, 1'b0); end
    endcase
  endtask

  task automatic run_steps(input string tag);
    int n;
    n = st_l.size();
    for (int i = 0; i < n; i++) exp_q.push_back(model_vec(st_l[i], rdy_l[i], rst_l[i]));
    for (int i = 0; i < n; i++) begin
      rst       = rst_l[i];
      mem_ready = rdy_l[i];
      @(negedge clk);
      check($sformatf("%s c%0d", tag, i),
            {state, pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, reg_dst,
             mem2reg, alu_src_a, ext_op, pc_src, alu_src_b, ALUOp},
            exp_q.pop_front());
      @(posedge clk);
      #1;
    end
    st_l.delete(); rdy_l.delete(); rst_l.delete();
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] f,
                          input logic z, input int fw, input int mw);
    set_instr(op, f, z);
    plan_instr(fw, mw);
    run_steps(tag);
    exp_count++;
    check({tag, " count"}, instr_count, exp_count);
  endtask

  logic [5:0] r_functs[9];

  initial begin
    r_functs = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_SLL, F_SRL, F_SLT, F_AND, F_OR};
    rst = 1'b1; mem_ready = 1'b0;
    set_instr(OP_RTYPE, F_ADDU, 1'b0);
    @(posedge clk);
    #1;
    add_step(S_FETCH, 1'b1, 1'b1);
    add_step(S_FETCH, 1'b1, 1'b1);
    run_steps("reset");
    check("reset illegal", illegal, 1'b0);
    check("reset count", instr_count, 32'd0);

    do_instr("addu", OP_RTYPE, F_ADDU, 1'b0, 0, 0);
    do_instr("lw_wait", OP_LW, 6'h00, 1'b0, 0, 3);
    do_instr("beq_t", OP_BEQ, 6'h00, 1'b1, 0, 0);
    do_instr("beq_nt", OP_BEQ, 6'h00, 1'b0, 0, 0);
    do_instr("bne_t", OP_BNE, 6'h00, 1'b0, 0, 0);
    do_instr("bne_nt", OP_BNE, 6'h00, 1'b1, 0, 0);
    do_instr("j", OP_J, 6'h00, 1'b0, 0, 0);
    do_instr("sw_fwait", OP_SW, 6'h00, 1'b0, 2, 1);
    do_instr("addiu", OP_ADDIU, 6'h00, 1'b0, 0, 0);
    do_instr("ori", OP_ORI, 6'h00, 1'b0, 1, 0);
    do_instr("slti", OP_SLTI, 6'h00, 1'b0, 0, 0);
    do_instr("lui", OP_LUI, 6'h00, 1'b0, 0, 0);
    do_instr("lw", OP_LW, 6'h00, 1'b0, 0, 0);
    for (int k = 0; k < 8; k++)
      do_instr($sformatf("rnd_r%0d", k), OP_RTYPE, r_functs[$urandom_range(0, 8)],
               1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
    check("illegal clear", illegal, 1'b0);

    // illegal opcode: trap holds with no strobes and no retirement
    set_instr(6'h3F, 6'h00, 1'b0);
    add_step(S_FETCH, 1'b1, 1'b0);
    add_step(S_DECODE, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add_step(S_TRAP, 1'b1, 1'b0);
    run_steps("trap_op");
    check("trap illegal", illegal, 1'b1);
    check("trap count", instr_count, exp_count);
    add_step(S_TRAP, 1'b1, 1'b1);
    run_steps("trap_rst");
    exp_count = '0;
    check("trap_rst state", state, S_FETCH);
    check("trap_rst illegal", illegal, 1'b0);
    check("trap_rst count", instr_count, exp_count);

    // illegal R-type funct also traps
    set_instr(OP_RTYPE, 6'h3F, 1'b0);
    add_step(S_FETCH, 1'b1, 1'b0);
    add_step(S_DECODE, 1'b1, 1'b0);
    add_step(S_TRAP, 1'b1, 1'b0);
    add_step(S_TRAP, 1'b1, 1'b1);
    run_steps("trap_funct");

    // reset in the middle of a store wait abandons the access
    do_instr("addiu2", OP_ADDIU, 6'h00, 1'b0, 0, 0);
    set_instr(OP_SW, 6'h00, 1'b0);
    add_step(S_FETCH, 1'b1, 1'b0);
    add_step(S_DECODE, 1'b1, 1'b0);
    add_step(S_MEM_ADDR, 1'b1, 1'b0);
    add_step(S_MEM_WR, 1'b0, 1'b0);
    add_step(S_MEM_WR, 1'b0, 1'b1);
    add_step(S_FETCH, 1'b0, 1'b0);
    run_steps("sw_rst");
    exp_count = '0;
    check("sw_rst count", instr_count, exp_count);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
